esm_issue_scheduler: RTL
========================

# esm_issue_scheduler

Consumer-side counterpart of the ESM dependency-analysis core. It owns the instruction buffer slots, allocates a `buffer_index` to each incoming instruction, and drives `valid_entries` into the dependency tables. It consumes the returned `independent_instr` mask, issues ready instructions one per cycle over a valid/ready port, and frees each slot on an execution-complete notification. It sits between decode and the execution units.

## Interface
- `Instruction_word_size`, 32, instruction width in bits
- `bs`, 16, buffer slots; power of two, at least 2
- `clk` input 1: single clock, rising edge
- `rst` input 1: reset; synchronous, active-high
- `alloc_valid` input 1: decode offers an instruction
- `alloc_instr` input `Instruction_word_size`: offered instruction
- `alloc_ready` output 1: at least one slot FREE
- `buffer_index` output `$clog2(bs)`: slot to be written; lowest-index FREE slot, 0 when none
- `valid_entries` output `[0:bs-1]`: bit i = slot i is WAIT or ISSUED
- `independent_instr` input `[0:bs-1]`: bit i = slot i has no outstanding producer
- `issue_valid` output 1: issue register holds an instruction
- `issue_ready` input 1: execution accepts
- `issue_index` output `$clog2(bs)`: slot of the issued instruction
- `issue_instr` output `Instruction_word_size`: issued instruction word
- `cmpl_valid` input 1: execution finished an instruction
- `cmpl_index` input `$clog2(bs)`: slot that finished
- `cmpl_err` output 1: one-cycle pulse on an illegal completion

## Operation
- Per-slot state: FREE -> WAIT (alloc) -> ISSUED (selected) -> FREE (completion). Slots also hold a payload register.
- Allocation:
  - Fires when `alloc_valid & alloc_ready`.
  - The slot at `buffer_index` takes `alloc_instr` and becomes WAIT.
  - `alloc_ready` and `buffer_index` are combinational from registered state only.
- Selection:
  - Candidates = WAIT & `independent_instr`.
  - The lowest index wins.
  - The issue register loads when it is empty or `issue_valid & issue_ready`.
  - On load, the chosen slot becomes ISSUED at the same edge, and its index and payload are captured.
  - With no candidate, `issue_valid` deasserts after a handshake.
- Issue handshake:
  - While `issue_valid=1` and `issue_ready=0`, `issue_index` and `issue_instr` are held stable.
  - An issue transfer occurs on `issue_valid & issue_ready`.
- Completion:
  - `cmpl_valid` with slot `cmpl_index` in ISSUED moves that slot to FREE and clears its `valid_entries` bit next cycle.
  - Completion of a slot that is FREE or WAIT has no state effect and pulses `cmpl_err` next cycle.
  - Completion of the slot currently held un-accepted in the issue register is also illegal: no effect, `cmpl_err` pulses.
- Simultaneous events:
  - Alloc plus completion: a slot freed this cycle is not allocatable until the next cycle.
  - Alloc plus select: a slot allocated this cycle cannot be selected this cycle.
  - All three events in one cycle are independent and all take effect.
- Full buffer: `alloc_ready=0` and `buffer_index=0`; `alloc_valid` is ignored.

## Timing
- Reset values:
  - all slots FREE
  - `valid_entries`=0
  - `alloc_ready`=1
  - `buffer_index`=0
  - `issue_valid`=0
  - `issue_index`=0
  - `issue_instr`=0
  - `cmpl_err`=0
  - stats counters 0
- `rst` takes effect at the next edge, even mid-handshake; an un-accepted issue is dropped.
- Latency:
  - alloc at edge N -> `valid_entries` bit set after N.
  - If `independent_instr` is set for that bit during cycle N+1, `issue_valid` rises after edge N+1.
  - Minimum alloc-to-issue is 2 edges.
- Completion at edge M -> slot allocatable in cycle M+1.
- Throughput: one alloc, one issue and one completion per cycle.

## Configuration
- `ESM_ISSUE_STATS_EN` defined adds two outputs:
  - `stat_issued` (32 bits): increments on each issue transfer.
  - `stat_stall` (32 bits): increments each cycle with `issue_valid & ~issue_ready`.
  - Both wrap modulo 2^32 and reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Reset then single instruction.** Reset, then alloc 0x00A00093 with `independent_instr`=all ones.
  - `buffer_index`=0 at alloc.
  - `valid_entries[0]`=1 next cycle.
  - `issue_valid`=1, `issue_index`=0, `issue_instr`=0x00A00093 two edges after alloc.
- **Fill and full.** Alloc 16 times with `independent_instr`=0.
  - Indices 0..15 in order.
  - Then `alloc_ready`=0, `valid_entries`=all ones, a 17th alloc is ignored.
  - `cmpl_valid` on an index that is not ISSUED pulses `cmpl_err`.
- **Priority and backpressure.** Slots 2, 5, 9 WAIT; independent mask has bits 5 and 9; `issue_ready`=0 for 3 cycles.
  - `issue_index`=5 is held stable for those 3 cycles.
  - After the handshake, `issue_index`=9.
- **Complete and reuse.** Issue slot 3, complete slot 3 at edge M.
  - `valid_entries[3]`=0 after M.
  - In the same cycle as the completion, a simultaneous alloc gets a different index.
  - Slot 3 is allocatable in cycle M+1.
- **Illegal completion.** Complete slot 4 while it is WAIT.
  - `cmpl_err`=1 for exactly one cycle.
  - Slot 4 remains WAIT.
- **Reset mid-handshake.** Assert `rst` while `issue_valid`=1 and `issue_ready`=0.
  - All outputs at reset values next cycle.
  - With `ESM_ISSUE_STATS_EN`, `stat_stall` counts stalled cycles and returns to 0.

Source files
------------

// File: rtl/esm_issue_scheduler_if.sv
// Bus bundle between the ESM issue scheduler and its decode, dependency-table and execution neighbours.
// The slave modport is the scheduler's view; master is the surrounding pipeline.
interface esm_issue_scheduler_if #(
  parameter int Instruction_word_size = 32,
  parameter int bs = 16
);
  localparam int IW = $clog2(bs);

  logic                             alloc_valid;
  logic [Instruction_word_size-1:0] alloc_instr;
  logic                             alloc_ready;
  logic [IW-1:0]                    buffer_index;
  logic [0:bs-1]                    valid_entries;
  logic [0:bs-1]                    independent_instr;
  logic                             issue_valid;
  logic                             issue_ready;
  logic [IW-1:0]                    issue_index;
  logic [Instruction_word_size-1:0] issue_instr;
  logic                             cmpl_valid;
  logic [IW-1:0]                    cmpl_index;
  logic                             cmpl_err;

  modport slave (
    input  alloc_valid, alloc_instr, independent_instr, issue_ready, cmpl_valid, cmpl_index,
    output alloc_ready, buffer_index, valid_entries, issue_valid, issue_index, issue_instr, cmpl_err
  );

  modport master (
    output alloc_valid, alloc_instr, independent_instr, issue_ready, cmpl_valid, cmpl_index,
    input  alloc_ready, buffer_index, valid_entries, issue_valid, issue_index, issue_instr, cmpl_err
  );
endinterface

// File: rtl/esm_issue_scheduler.sv
// ESM issue scheduler: slot allocation, lowest-index issue selection, completion-driven slot release.
// Defining ESM_ISSUE_STATS_EN adds the stat_issued / stat_stall counters.
module esm_issue_scheduler #(
  parameter int Instruction_word_size = 32,
  parameter int bs = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  esm_issue_scheduler_if.slave        bus
`ifdef ESM_ISSUE_STATS_EN
  ,
  output logic [31:0]                 stat_issued,
  output logic [31:0]                 stat_stall
`endif
);
  localparam int IW = $clog2(bs);

  typedef enum logic [1:0] {SLOT_FREE, SLOT_WAIT, SLOT_ISSUED} slot_state_e;

  slot_state_e                      slot_q [bs];
  slot_state_e                      slot_d [bs];
  logic [Instruction_word_size-1:0] payload_q [bs];

  logic                             issue_valid_q, issue_valid_d;
  logic [IW-1:0]                    issue_index_q, issue_index_d;
  logic [Instruction_word_size-1:0] issue_instr_q, issue_instr_d;
  logic                             cmpl_err_q, cmpl_err_d;

  logic [bs-1:0] free_mask, cand_mask;
  logic          any_free, any_cand;
  logic [IW-1:0] free_index, cand_index;
  logic          alloc_fire, issue_load, cmpl_ok;

  // Both encoders look only at registered slot state, so a slot allocated or freed
  // this cycle cannot be selected or reallocated until the following cycle.
  always_comb begin
    free_mask  = '0;
    cand_mask  = '0;
    free_index = '0;
    cand_index = '0;
    for (int i = 0; i < bs; i++) begin
      free_mask[i] = (slot_q[i] == SLOT_FREE);
      cand_mask[i] = (slot_q[i] == SLOT_WAIT) && bus.independent_instr[i];
    end
    for (int i = bs - 1; i >= 0; i--) begin
      if (free_mask[i]) free_index = IW'(i);
      if (cand_mask[i]) cand_index = IW'(i);
    end
    any_free = |free_mask;
    any_cand = |cand_mask;
  end

  always_comb begin
    alloc_fire = bus.alloc_valid & any_free;
    issue_load = ~issue_valid_q | bus.issue_ready;
    // A slot still sitting un-accepted in the issue register cannot legally complete.
    cmpl_ok    = (slot_q[bus.cmpl_index] == SLOT_ISSUED) &&
                 !(issue_valid_q && !bus.issue_ready && (issue_index_q == bus.cmpl_index));

    for (int i = 0; i < bs; i++) begin
      slot_d[i] = slot_q[i];
      if (alloc_fire && (free_index == IW'(i)))
        slot_d[i] = SLOT_WAIT;
      if (issue_load && any_cand && (cand_index == IW'(i)))
        slot_d[i] = SLOT_ISSUED;
      if (bus.cmpl_valid && cmpl_ok && (bus.cmpl_index == IW'(i)))
        slot_d[i] = SLOT_FREE;
    end

    issue_valid_d = issue_valid_q;
    issue_index_d = issue_index_q;
    issue_instr_d = issue_instr_q;
    if (issue_load) begin
      issue_valid_d = any_cand;
      if (any_cand) begin
        issue_index_d = cand_index;
        issue_instr_d = payload_q[cand_index];
      end
    end

    cmpl_err_d = bus.cmpl_valid & ~cmpl_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < bs; i++) slot_q[i] <= SLOT_FREE;
      issue_valid_q <= 1'b0;
      issue_index_q <= '0;
      issue_instr_q <= '0;
      cmpl_err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < bs; i++) slot_q[i] <= slot_d[i];
      issue_valid_q <= issue_valid_d;
      issue_index_q <= issue_index_d;
      issue_instr_q <= issue_instr_d;
      cmpl_err_q    <= cmpl_err_d;
    end
  end

  // Payloads are pure datapath; slot state alone decides whether they are meaningful.
  always_ff @(posedge clk) begin
    if (alloc_fire) payload_q[free_index] <= bus.alloc_instr;
  end

  always_comb begin
    bus.valid_entries = '0;
    for (int i = 0; i < bs; i++) bus.valid_entries[i] = (slot_q[i] != SLOT_FREE);
    bus.alloc_ready  = any_free;
    bus.buffer_index = free_index;
    bus.issue_valid  = issue_valid_q;
    bus.issue_index  = issue_index_q;
    bus.issue_instr  = issue_instr_q;
    bus.cmpl_err     = cmpl_err_q;
  end

`ifdef ESM_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue_valid_q & bus.issue_ready)  stat_issued <= stat_issued + 32'd1;
      if (issue_valid_q & ~bus.issue_ready) stat_stall  <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
